// File: rtl/rv32i_control_fsm_pkg.sv
// Shared constants and types for the multi-cycle RV32I sequencer.
package rv32i_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Major opcodes (instr[6:0]) recognised by the decoder
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   // Bit positions inside the one-hot dec_class vector
   localparam int unsigned CLS_BRANCH = 0;
   localparam int unsigned CLS_JALR   = 1;
   localparam int unsigned CLS_JAL    = 2;
   localparam int unsigned CLS_LUI    = 3;
   localparam int unsigned CLS_AUIPC  = 4;
   localparam int unsigned CLS_OP_IMM = 5;
   localparam int unsigned CLS_OP     = 6;
   localparam int unsigned CLS_LOAD   = 7;
   localparam int unsigned CLS_STORE  = 8;
   localparam int unsigned CLS_FENCE  = 9;
   localparam int unsigned CLS_W      = 10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2
   } wb_sel_e;

   function automatic logic is_onehot(input logic [CLS_W-1:0] v);
      return (v != '0) && ((v & (v - 10'd1)) == '0);
   endfunction

endpackage

// File: rtl/rv32i_control_fsm_if.sv
// Instruction and data memory handshake bundle.
interface rv32i_control_fsm_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/rv32i_control_fsm_pc_unit.sv
// PC register with pc+4 / target mux and next-PC alignment check.
module rv32i_pc_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        upd,
   input  logic        sel_target,
   input  logic [31:0] target_addr,
   output logic [31:0] pc,
   output logic        fault
);

   logic [31:0] pc_q, pc_d, pc_next;

   // Select next PC, flag misalignment, and only commit aligned values
   always_comb begin
      pc_next = sel_target ? target_addr : pc_q + 32'd4;
      fault   = |pc_next[1:0];
      pc_d    = pc_q;
      if (upd && !fault) pc_d = pc_next;
   end

   // PC register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the minimal RV32I core.
module rv32i_control_fsm
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rv32i_control_fsm_if.master  bus,
   output logic [31:0]          instr,
   input  logic [CLS_W-1:0]     dec_class,
   input  logic                 branch_taken,
   input  logic [31:0]          target_addr,
   output logic                 rf_we,
   output logic [1:0]           wb_sel,
   output logic [31:0]          pc,
   output logic                 trap,
   output logic [2:0]           state
);

   state_e            state_q, state_d;
   logic [31:0]       instr_q, instr_d;
   logic [CLS_W-1:0]  cls_q, cls_d;
   logic              trap_q, trap_d;
   logic              pc_upd, pc_sel_tgt, pc_fault, is_jump;
   wb_sel_e           wb_sel_e_v;

   rv32i_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
      .clk         (clk),
      .rst_n       (rst_n),
      .upd         (pc_upd),
      .sel_target  (pc_sel_tgt),
      .target_addr (target_addr),
      .pc          (pc),
      .fault       (pc_fault)
   );

   assign is_jump = cls_q[CLS_JAL] | cls_q[CLS_JALR];

   // State, instruction register, latched class and sticky trap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         instr_q <= '0;
         cls_q   <= '0;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         cls_q   <= cls_d;
         trap_q  <= trap_d;
      end
   end

   // PC update request and source select; in EXEC a jump only probes its
   // target so a misaligned target halts before any register write
   always_comb begin
      pc_upd     = 1'b0;
      pc_sel_tgt = 1'b0;
      case (state_q)
         S_EXEC: begin
            if (cls_q[CLS_BRANCH]) begin
               pc_upd     = 1'b1;
               pc_sel_tgt = branch_taken;
            end else if (cls_q[CLS_FENCE]) begin
               pc_upd = 1'b1;
            end else if (is_jump) begin
               pc_sel_tgt = 1'b1;
            end
         end
         S_MEM:   pc_upd = bus.dmem_ack && cls_q[CLS_STORE];
         S_WB: begin
            pc_upd     = 1'b1;
            pc_sel_tgt = is_jump;
         end
         default: ;
      endcase
   end

   // Next-state, instruction capture and trap logic
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      cls_d   = cls_q;
      case (state_q)
         S_FETCH: begin
            if (bus.imem_ack) begin
               instr_d = bus.imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            cls_d   = dec_class;
            state_d = is_onehot(dec_class) ? S_EXEC : S_HALT;
         end
         S_EXEC: begin
            if (cls_q[CLS_LOAD] || cls_q[CLS_STORE])   state_d = S_MEM;
            else if (cls_q[CLS_BRANCH])                state_d = pc_fault ? S_HALT : S_FETCH;
            else if (cls_q[CLS_FENCE])                 state_d = S_FETCH;
            else if (is_jump)                          state_d = pc_fault ? S_HALT : S_WB;
            else                                       state_d = S_WB;
         end
         S_MEM: begin
            if (bus.dmem_ack) state_d = cls_q[CLS_STORE] ? S_FETCH : S_WB;
         end
         S_WB:    state_d = pc_fault ? S_HALT : S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
      trap_d = trap_q | (state_d == S_HALT);
   end

   // Outputs decoded from registered state; imem_req is also gated by
   // rst_n so an in-flight fetch request drops as soon as reset asserts
   always_comb begin
      bus.imem_req  = rst_n && (state_q == S_FETCH);
      bus.imem_addr = pc;
      bus.dmem_req  = (state_q == S_MEM);
      bus.dmem_we   = (state_q == S_MEM) && cls_q[CLS_STORE];
      rf_we         = (state_q == S_WB);
      if (cls_q[CLS_LOAD]) wb_sel_e_v = WB_LOAD;
      else if (is_jump)    wb_sel_e_v = WB_PC4;
      else                 wb_sel_e_v = WB_ALU;
      wb_sel        = wb_sel_e_v;
      instr         = instr_q;
      trap          = trap_q;
      state         = state_q;
   end

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Randomized self-checking bench for rv32i_control_fsm.
module tb_rv32i_control_fsm;
   import rv32i_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [31:0]       instr;
   logic [CLS_W-1:0]  dec_class = '0;
   logic              branch_taken = 1'b0;
   logic [31:0]       target_addr = '0;
   logic              rf_we;
   logic [1:0]        wb_sel;
   logic [31:0]       pc;
   logic              trap;
   logic [2:0]        state;

   int checks = 0;
   int errors = 0;
   logic [31:0] pc_m;

   typedef struct {
      logic [CLS_W-1:0] dc;
      int               iw;
      int               dw;
      logic             taken;
      logic [31:0]      tgt;
      logic [31:0]      rdata;
   } txn_t;

   always #5 clk = ~clk;

   rv32i_control_fsm_if bus ();

   rv32i_control_fsm #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .instr        (instr),
      .dec_class    (dec_class),
      .branch_taken (branch_taken),
      .target_addr  (target_addr),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .pc           (pc),
      .trap         (trap),
      .state        (state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input bit check_vals);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      if (check_vals) begin
         chk("rst_pc", pc, RST_PC);
         chk("rst_instr", instr, 32'h0);
         chk("rst_trap", trap, 1'b0);
         chk("rst_rf_we", rf_we, 1'b0);
         chk("rst_dmem_req", bus.dmem_req, 1'b0);
         chk("rst_dmem_we", bus.dmem_we, 1'b0);
         chk("rst_imem_req", bus.imem_req, 1'b0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      if (check_vals) chk("imem_req_after_rst", bus.imem_req, 1'b1);
   endtask

   function automatic txn_t mk(input logic [CLS_W-1:0] dc, input int iw, input int dw,
                               input logic taken, input logic [31:0] tgt);
      txn_t t;
      t.dc = dc; t.iw = iw; t.dw = dw; t.taken = taken; t.tgt = tgt;
      t.rdata = $urandom;
      return t;
   endfunction

   function automatic logic [CLS_W-1:0] oh(input int unsigned idx);
      return 10'(1) << idx;
   endfunction

   // Runs one instruction starting at a FETCH cycle (sampled on negedge),
   // acting as memory, and checks it against the architectural expectation
   task automatic run_txn(input txn_t t);
      logic legal, is_ld, is_st, is_br, is_fn, is_jmp, to_tgt, mis, exp_trap, exp_wr;
      int exp_cyc, exp_dreq;
      logic [31:0] nxt, exp_pc;
      logic [1:0] exp_sel, sel_seen;
      int cyc, icnt, dcnt, dreq_cyc, we_cnt, we_cyc;
      logic acked, done, halted, dwe_ok;

      legal  = ($countones(t.dc) == 1);
      is_ld  = t.dc[CLS_LOAD];
      is_st  = t.dc[CLS_STORE];
      is_br  = t.dc[CLS_BRANCH];
      is_fn  = t.dc[CLS_FENCE];
      is_jmp = t.dc[CLS_JAL] | t.dc[CLS_JALR];
      to_tgt = (is_br && t.taken) || is_jmp;
      nxt    = to_tgt ? t.tgt : pc_m + 32'd4;
      mis    = legal && to_tgt && (nxt[1:0] != 2'b00);
      exp_trap = !legal || mis;
      if (!legal)                exp_cyc = t.iw + 2;
      else if (mis)              exp_cyc = t.iw + 3;
      else if (is_ld)            exp_cyc = t.iw + t.dw + 5;
      else if (is_st)            exp_cyc = t.iw + t.dw + 4;
      else if (is_br || is_fn)   exp_cyc = t.iw + 3;
      else                       exp_cyc = t.iw + 4;
      exp_wr   = legal && !mis && !(is_br || is_st || is_fn);
      exp_dreq = (legal && (is_ld || is_st)) ? t.dw + 1 : 0;
      exp_sel  = is_ld ? 2'd1 : (is_jmp ? 2'd2 : 2'd0);
      exp_pc   = exp_trap ? pc_m : nxt;

      dec_class    = t.dc;
      branch_taken = t.taken;
      target_addr  = t.tgt;
      chk("imem_addr", bus.imem_addr, pc_m);
      chk("fetch_req", bus.imem_req, 1'b1);

      cyc = 0; icnt = 0; dcnt = 0; dreq_cyc = 0; we_cnt = 0; we_cyc = 0;
      acked = 1'b0; done = 1'b0; halted = 1'b0; dwe_ok = 1'b1; sel_seen = 2'd3;
      while (!done && cyc < 64) begin
         if (acked && bus.imem_req) begin
            done = 1'b1;
         end else if (trap) begin
            done = 1'b1;
            halted = 1'b1;
         end else begin
            cyc++;
            if (bus.imem_req) begin
               bus.imem_rdata = t.rdata;
               bus.imem_ack   = (icnt == t.iw);
               if (icnt == t.iw) acked = 1'b1;
               icnt++;
            end else begin
               bus.imem_rdata = $urandom;
               bus.imem_ack   = 1'($urandom_range(0, 1));
            end
            if (bus.dmem_req) begin
               dreq_cyc++;
               if (bus.dmem_we !== is_st) dwe_ok = 1'b0;
               bus.dmem_ack = (dcnt == t.dw);
               dcnt++;
            end else begin
               bus.dmem_ack = 1'($urandom_range(0, 1));
            end
            if (rf_we) begin
               we_cnt++;
               we_cyc = cyc;
               sel_seen = wb_sel;
            end
            @(negedge clk);
         end
      end

      chk("finished", done, 1'b1);
      chk("cycles", cyc, exp_cyc);
      chk("trap", trap, exp_trap);
      chk("pc", pc, exp_pc);
      chk("instr", instr, t.rdata);
      chk("rf_we_cnt", we_cnt, exp_wr);
      if (exp_wr) begin
         chk("rf_we_cyc", we_cyc, exp_cyc);
         chk("wb_sel", sel_seen, exp_sel);
      end
      chk("dmem_cycles", dreq_cyc, exp_dreq);
      chk("dmem_we", dwe_ok, 1'b1);

      if (halted || exp_trap || !done) begin
         repeat (3) begin
            bus.imem_ack = 1'b1;
            bus.dmem_ack = 1'b1;
            @(negedge clk);
            chk("halt_imem_req", bus.imem_req, 1'b0);
            chk("halt_dmem_req", bus.dmem_req, 1'b0);
            chk("halt_rf_we", rf_we, 1'b0);
         end
         do_reset(1'b0);
         pc_m = RST_PC;
      end else begin
         pc_m = exp_pc;
      end
   endtask

   initial begin
      txn_t t;
      logic [CLS_W-1:0] dc;
      int a, b;

      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      bus.imem_rdata = '0;
      @(negedge clk);
      do_reset(1'b1);
      pc_m = RST_PC;

      // ADDI, LW with 3-cycle dmem wait, BEQ taken / not taken
      run_txn(mk(oh(CLS_OP_IMM), 0, 0, 1'b0, 32'h0));
      run_txn(mk(oh(CLS_LOAD), 0, 3, 1'b0, 32'h0));
      run_txn(mk(oh(CLS_BRANCH), 0, 0, 1'b1, 32'h40));
      run_txn(mk(oh(CLS_BRANCH), 0, 0, 1'b0, 32'h80));

      // Store interrupted by reset while waiting for dmem_ack
      dec_class = oh(CLS_STORE);
      bus.imem_rdata = 32'h0011_2023;
      bus.imem_ack = 1'b1;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("st_dmem_req", bus.dmem_req, 1'b1);
      chk("st_dmem_we", bus.dmem_we, 1'b1);
      @(negedge clk);
      chk("st_dmem_wait", bus.dmem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mem_dmem_req", bus.dmem_req, 1'b0);
      chk("rst_mem_pc", pc, RST_PC);
      bus.dmem_ack = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("late_ack_dmem_req", bus.dmem_req, 1'b0);
      chk("late_ack_imem_req", bus.imem_req, 1'b1);
      chk("late_ack_pc", pc, RST_PC);
      bus.dmem_ack = 1'b0;
      pc_m = RST_PC;

      // Misaligned JAL target, illegal classes
      run_txn(mk(oh(CLS_JAL), 0, 0, 1'b0, 32'h102));
      run_txn(mk(10'b0, 0, 0, 1'b0, 32'h0));
      run_txn(mk(10'b11, 0, 0, 1'b0, 32'h0));

      // PC wrap: branch to the last word, then ADDI
      run_txn(mk(oh(CLS_BRANCH), 1, 0, 1'b1, 32'hFFFF_FFFC));
      run_txn(mk(oh(CLS_OP_IMM), 0, 0, 1'b0, 32'h0));

      // Random instruction stream
      for (int n = 0; n < 150; n++) begin
         a = $urandom_range(0, 19);
         if (a < 17) begin
            dc = oh($urandom_range(0, 9));
         end else if (a == 17) begin
            dc = '0;
         end else begin
            a = $urandom_range(0, 9);
            b = (a + $urandom_range(1, 9)) % 10;
            dc = oh(a) | oh(b);
         end
         t = mk(dc, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom & 32'hFFFF_FFFC);
         if ($urandom_range(0, 7) == 0) t.tgt[1:0] = 2'($urandom_range(1, 3));
         run_txn(t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
